mem_bus_bridge: RTL and testbench
=================================

# mem_bus_bridge

Parametrised memory-mapped bus bridge between the CPU memory port (`mem_cmd`/`mem_addr`) and one synchronous-read RAM plus `N_IO` memory-mapped IO registers. It replaces ad-hoc combinational decode in the top level with a registered, multi-cycle transaction engine. The engine provides a `mem_ready` handshake, programmable wait states, per-channel IO output registers with write strobes, readable IO inputs, and bus-error reporting for unmapped or illegal accesses.

## Interface

**Parameters**
- `DATA_W`, default 16: data bus width.
- `ADDR_W`, default 9: CPU address width. The MSB selects IO space.
- `RAM_AW`, default 8: RAM address width. Must satisfy `RAM_AW <= ADDR_W-1`.
- `N_IO`, default 2: number of IO channels, 1..16. `IDX_W = max(1, clog2(N_IO))`.
- `WAIT`, default 1: extra ACCESS cycles, 0..15.

**Ports** (clock and reset first)
- `clk` input 1: single clock. Everything is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `mem_cmd` input 2: `M_NOP`=00, `M_WRITE`=01, `M_READ`=10. 11 is illegal.
- `mem_addr` input `ADDR_W`: CPU address.
- `cpu_wdata` input `DATA_W`: write data.
- `cpu_rdata` output `DATA_W`: read data, registered.
- `mem_ready` output 1: one-cycle transaction-complete pulse.
- `bus_err` output 1: error flag, valid while `mem_ready`=1.
- `ram_addr` output `RAM_AW`: RAM address.
- `ram_write` output 1: RAM write enable.
- `ram_din` output `DATA_W`: RAM write data.
- `ram_dout` input `DATA_W`: RAM read data, one-cycle synchronous read.
- `io_in` input `N_IO*DATA_W`: IO input channels. Channel i is at `[i*DATA_W +: DATA_W]`.
- `io_out` output `N_IO*DATA_W`: IO output registers.
- `io_wstrobe` output `N_IO`: one-cycle pulse per IO channel written.

## Operation

**Address decode** (from latched address)
- `addr[ADDR_W-1]`=0 is RAM. RAM address is `addr[RAM_AW-1:0]`. Bits `[ADDR_W-2:RAM_AW]` must be 0, otherwise the access is an error.
- `addr[ADDR_W-1]`=1 is IO. Channel index is `addr[IDX_W-1:0]`. An index `>= N_IO`, or any nonzero bit in `[ADDR_W-2:IDX_W]`, is an error.

**FSM states and transitions**
- IDLE to ACCESS when `mem_cmd` is `M_READ` or `M_WRITE`. On that edge, latch cmd, addr and wdata, clear the counter, and clear `bus_err`.
- IDLE to RESP when `mem_cmd`=11, with the error flag set.
- ACCESS: the counter counts 0..`WAIT`. ACCESS goes to RESP on the edge where counter==`WAIT`.
  - **RAM read:** `ram_dout` is captured into `cpu_rdata` on that edge.
  - **IO read:** the selected `io_in` channel (synchronised when `IO_SYNC_EN` is defined) is captured into `cpu_rdata` on that edge.
  - **Error reads:** capture 0.
- RESP: `mem_ready`=1 for exactly one cycle, then IDLE.

**ACCESS-phase outputs**
- `ram_addr` and `ram_din` are driven from the latched registers throughout ACCESS and hold their last value otherwise.
- `ram_write`=1 only in the first ACCESS cycle (counter==0) of a RAM write with no error.
- An IO write updates `io_out[idx]` and pulses `io_wstrobe[idx]` on the edge leaving counter==0.

**Error accesses**
- No RAM write, no IO update, no strobe.
- `bus_err`=1 together with `mem_ready`.

**Other rules**
- `mem_cmd` is ignored outside IDLE. The CPU may hold or drop it.
- `cpu_rdata` holds its value until the next read completes. Writes leave it unchanged.

## Timing

- Accept edge E0. ACCESS occupies `WAIT+1` cycles. `mem_ready` is high in the cycle after edge E0+`WAIT`+1.
- Command-to-ready latency is `WAIT+2` cycles. Minimum issue interval is `WAIT+3` cycles.
- With `WAIT`=0 the RAM still gets its one-cycle read.

**Reset**
- Reset is synchronous and active-low. On a reset edge: state IDLE, counter 0, `cpu_rdata`=0, `mem_ready`=0, `bus_err`=0, `io_out`=0, `io_wstrobe`=0, `ram_addr`=0, `ram_din`=0.
- `ram_write` is gated low in any cycle where `reset`=0, so a transaction interrupted mid-ACCESS performs no RAM write after reset asserts.
- Synchroniser flops reset to 0.
- Reset mid-transaction aborts it with no `mem_ready`.

## Configuration

- `MEM_BUS_IO_SYNC_EN` defined: each `io_in` channel passes through a 2-flop synchroniser. IO reads return the value sampled 2 cycles earlier.
- Undefined: `io_in` is sampled directly at the capture edge. There is no synchroniser logic.

## Structure

- Package `mem_bus_pkg` holds:
  - the `M_NOP`/`M_READ`/`M_WRITE` localparams;
  - the state enum `{S_IDLE, S_ACCESS, S_RESP}`;
  - the `mem_cmd_t` 2-bit typedef.
- Sub-module `sync2`: a parametrised-width 2-flop synchroniser, instantiated per channel under `MEM_BUS_IO_SYNC_EN`.
- Everything else lives in the single `mem_bus_bridge` module.

## Test plan

- **RAM write then read.** With `WAIT`=1, write 16'hBEEF to 9'h023, then read 9'h023.
  - Write: `ram_write` high for exactly 1 cycle, `ram_addr`=8'h23, `mem_ready` 3 cycles after the command.
  - Read: `cpu_rdata`=16'hBEEF, `bus_err`=0.
- **IO write.** Write 16'h00A5 to 9'h101 → `io_out[31:16]`=16'h00A5, `io_wstrobe`=2'b10 for 1 cycle, `ram_write` never asserted.
- **IO read.** Hold `io_in[15:0]`=16'h1234 stable, read 9'h100 → `cpu_rdata`=16'h1234. Run with and without `MEM_BUS_IO_SYNC_EN`.
- **Unmapped and illegal accesses.**
  - Read 9'h102 (`N_IO`=2) → `cpu_rdata`=0, `bus_err`=1.
  - `mem_cmd`=11 → `mem_ready` after 1 cycle with `bus_err`=1, no side effects.
- **Reset mid-access.** Assert `reset`=0 during the first ACCESS cycle of a RAM write to 9'h010 → no `ram_write`, no `mem_ready`, all outputs 0. A later read of 9'h010 returns the old contents.
- **Wait-state sweep.** `WAIT`=0 and `WAIT`=3, with `mem_cmd` held in `M_READ` continuously → ready every `WAIT`+3 cycles, latency `WAIT`+2, no double-accept.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-port bridge.
package mem_bus_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t M_NOP   = 2'b00;
  localparam mem_cmd_t M_WRITE = 2'b01;
  localparam mem_cmd_t M_READ  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Channel-index width: at least one bit even for a single channel.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_bridge_sync2.sv
// Two-flop synchroniser, parametrised width. Used per IO input channel
// when MEM_BUS_IO_SYNC_EN is defined.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Registered bridge from the CPU memory port to one synchronous-read RAM
// and N_IO memory-mapped IO registers. Multi-cycle transactions with
// WAIT extra access cycles, a one-cycle mem_ready pulse and bus_err for
// unmapped/illegal accesses.
// Optional feature: define MEM_BUS_IO_SYNC_EN to pass each io_in channel
// through a 2-flop synchroniser before it can be read.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RAM_AW = 8,
  parameter int N_IO   = 2,
  parameter int WAIT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mem_cmd,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     mem_ready,
  output logic                     bus_err,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic                     ram_write,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout,
  input  logic [N_IO*DATA_W-1:0]   io_in,
  output logic [N_IO*DATA_W-1:0]   io_out,
  output logic [N_IO-1:0]          io_wstrobe
);

  localparam int               IDX_W  = idx_w(N_IO);
  localparam logic [3:0]       WAIT_C = 4'(WAIT);
  localparam logic [IDX_W:0]   N_IO_C = (IDX_W+1)'(N_IO);

  state_t                      state, state_nxt;
  logic [3:0]                  cnt;
  mem_cmd_t                    cmd_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [RAM_AW-1:0]           ram_addr_q;
  logic [DATA_W-1:0]           wdata_q;
  logic [N_IO-1:0][DATA_W-1:0] io_q;
  logic [N_IO*DATA_W-1:0]      io_src;
  logic [DATA_W-1:0]           io_rd;
  logic [ADDR_W-2:0]           low_bits;
  logic [IDX_W-1:0]            idx;
  logic                        accept, illegal, last, is_io, dec_err;

  assign accept   = (state == S_IDLE) && (mem_cmd == M_READ || mem_cmd == M_WRITE);
  assign illegal  = (state == S_IDLE) && (mem_cmd == 2'b11);
  assign last     = (state == S_ACCESS) && (cnt == WAIT_C);
  assign is_io    = addr_q[ADDR_W-1];
  assign low_bits = addr_q[ADDR_W-2:0];
  assign idx      = addr_q[IDX_W-1:0];

  // Decode the latched address; any stray upper bit or missing channel is an error.
  always_comb begin
    dec_err = 1'b0;
    if (is_io)
      dec_err = ((low_bits >> IDX_W) != '0) || ({1'b0, idx} >= N_IO_C);
    else
      dec_err = (low_bits >> RAM_AW) != '0;
  end

`ifdef MEM_BUS_IO_SYNC_EN
  for (genvar g = 0; g < N_IO; g++) begin : g_sync
    sync2 #(.W(DATA_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (io_in[g*DATA_W +: DATA_W]),
      .q     (io_src[g*DATA_W +: DATA_W])
    );
  end
`else
  assign io_src = io_in;
`endif

  // Select the addressed IO input channel; unmatched index reads 0.
  always_comb begin
    io_rd = '0;
    for (int i = 0; i < N_IO; i++)
      if (idx == IDX_W'(i)) io_rd = io_src[i*DATA_W +: DATA_W];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> ACCESS on a legal command, straight to RESP on 11.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ACCESS;
                else if (illegal) state_nxt = S_RESP;
      S_ACCESS: if (cnt == WAIT_C) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Transaction datapath: latch on accept, IO write after first access cycle,
  // read capture and error flag on the last access edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      cmd_q      <= M_NOP;
      addr_q     <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
      io_q       <= '0;
      io_wstrobe <= '0;
    end else begin
      io_wstrobe <= '0;
      if (accept) begin
        cmd_q      <= mem_cmd;
        addr_q     <= mem_addr;
        ram_addr_q <= mem_addr[RAM_AW-1:0];
        wdata_q    <= cpu_wdata;
        cnt        <= '0;
        bus_err    <= 1'b0;
      end else if (illegal) begin
        bus_err    <= 1'b1;
      end
      if (state == S_ACCESS) begin
        cnt <= cnt + 4'd1;
        if (cnt == '0 && cmd_q == M_WRITE && is_io && !dec_err) begin
          for (int i = 0; i < N_IO; i++)
            if (idx == IDX_W'(i)) begin
              io_q[i]       <= wdata_q;
              io_wstrobe[i] <= 1'b1;
            end
        end
        if (last) begin
          bus_err <= dec_err;
          if (cmd_q == M_READ)
            cpu_rdata <= dec_err ? '0 : (is_io ? io_rd : ram_dout);
        end
      end
    end
  end

  // The address is presented during the accept cycle so the RAM's one-cycle
  // read completes by the capture edge even with WAIT=0; otherwise it holds
  // the latched value.
  assign ram_addr  = (accept && reset) ? mem_addr[RAM_AW-1:0] : ram_addr_q;
  assign ram_din   = wdata_q;
  assign ram_write = reset && (state == S_ACCESS) && (cnt == '0) &&
                     (cmd_q == M_WRITE) && !is_io && !dec_err;
  assign mem_ready = (state == S_RESP);
  assign io_out    = io_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: main instance with WAIT=1 plus two
// extra instances (WAIT=0, WAIT=3) for the held-command cadence sweep.
module tb_mem_bus_bridge;
  import mem_bus_pkg::*;

  localparam int DW = 16, AW = 9, RAW = 8, NIO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main instance, WAIT=1
  logic [1:0]         mem_cmd;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      cpu_wdata, cpu_rdata, ram_din, ram_dout;
  logic               mem_ready, bus_err, ram_write;
  logic [RAW-1:0]     ram_addr;
  logic [NIO*DW-1:0]  io_in, io_out;
  logic [NIO-1:0]     io_wstrobe;

  mem_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .N_IO(NIO), .WAIT(1)) dut (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .ram_addr(ram_addr), .ram_write(ram_write),
    .ram_din(ram_din), .ram_dout(ram_dout), .io_in(io_in), .io_out(io_out),
    .io_wstrobe(io_wstrobe)
  );

  // sweep instance a, WAIT=0 (RAM reads)
  logic [1:0] a_cmd; logic [AW-1:0] a_addr; logic [DW-1:0] a_wdata, a_rdata, a_ram_din, a_ram_dout;
  logic a_ready, a_err, a_ram_write; logic [RAW-1:0] a_ram_addr;
  logic [NIO*DW-1:0] a_io_in, a_io_out; logic [NIO-1:0] a_io_wstrobe;

  mem_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .N_IO(NIO), .WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset), .mem_cmd(a_cmd), .mem_addr(a_addr),
    .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .mem_ready(a_ready),
    .bus_err(a_err), .ram_addr(a_ram_addr), .ram_write(a_ram_write),
    .ram_din(a_ram_din), .ram_dout(a_ram_dout), .io_in(a_io_in), .io_out(a_io_out),
    .io_wstrobe(a_io_wstrobe)
  );

  // sweep instance b, WAIT=3 (IO reads)
  logic [1:0] b_cmd; logic [AW-1:0] b_addr; logic [DW-1:0] b_wdata, b_rdata, b_ram_din, b_ram_dout;
  logic b_ready, b_err, b_ram_write; logic [RAW-1:0] b_ram_addr;
  logic [NIO*DW-1:0] b_io_in, b_io_out; logic [NIO-1:0] b_io_wstrobe;

  mem_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .RAM_AW(RAW), .N_IO(NIO), .WAIT(3)) dut_w3 (
    .clk(clk), .reset(reset), .mem_cmd(b_cmd), .mem_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .mem_ready(b_ready),
    .bus_err(b_err), .ram_addr(b_ram_addr), .ram_write(b_ram_write),
    .ram_din(b_ram_din), .ram_dout(b_ram_dout), .io_in(b_io_in), .io_out(b_io_out),
    .io_wstrobe(b_io_wstrobe)
  );

  // RAM model for the main instance: one-cycle synchronous read
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_write) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // pattern ROMs for the sweep instances: data = {A0, address}
  always @(posedge clk) begin
    a_ram_dout <= {8'hA0, a_ram_addr};
    b_ram_dout <= {8'hB0, b_ram_addr};
  end

  // side-effect monitors
  int wr_cnt = 0, stb_cnt = 0;
  logic [NIO-1:0] stb_last = '0;
  always @(posedge clk) begin
    if (ram_write) wr_cnt <= wr_cnt + 1;
    if (io_wstrobe != '0) begin
      stb_cnt  <= stb_cnt + 1;
      stb_last <= io_wstrobe;
    end
  end

  int n_pass = 0, n_fail = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Issue one command, wait (bounded) for mem_ready, compare against scoreboard.
  task automatic txn(input string tag, input logic [1:0] c, input logic [8:0] a,
                     input logic [15:0] wd, input logic [15:0] erd, input logic eerr,
                     input int elat, output logic [7:0] ra_acc);
    exp_t e;
    int   lat;
    bit   seen;
    e.rdata = erd; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    @(negedge clk);
    mem_cmd = c; mem_addr = a; cpu_wdata = wd;
    lat = 0; seen = 0; ra_acc = '0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      mem_cmd = M_NOP;
      lat++;
      if (lat == 1) ra_acc = ram_addr;
      if (mem_ready === 1'b1) seen = 1;
    end
    e = sb.pop_front();
    chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
    chk({tag, ".rdata"}, 32'(cpu_rdata), 32'(e.rdata));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(e.err));
    @(negedge clk);
    chk({tag, ".ready_1cyc"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra;
    int wr0, stb0, na, nb, pa, pb;
    bit rdy_seen;

    reset = 1'b0;
    mem_cmd = M_NOP; mem_addr = '0; cpu_wdata = '0; io_in = '0;
    a_cmd = M_NOP; a_addr = 9'h045; a_wdata = '0; a_io_in = '0;
    b_cmd = M_NOP; b_addr = 9'h101; b_wdata = '0; b_io_in = {16'h7E57, 16'h0000};
    repeat (3) @(negedge clk);

    // reset state
    chk("rst.cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst.mem_ready", 32'(mem_ready), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    chk("rst.io_out", io_out, 32'd0);
    chk("rst.io_wstrobe", 32'(io_wstrobe), 32'd0);
    chk("rst.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst.ram_din", 32'(ram_din), 32'd0);
    chk("rst.ram_write", 32'(ram_write), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // RAM write then read
    wr0 = wr_cnt;
    txn("ram_wr", M_WRITE, 9'h023, 16'hBEEF, 16'h0000, 1'b0, 3, ra);
    chk("ram_wr.ram_addr", 32'(ra), 32'h23);
    chk("ram_wr.write_cycles", 32'(wr_cnt - wr0), 32'd1);
    txn("ram_rd", M_READ, 9'h023, 16'h0000, 16'hBEEF, 1'b0, 3, ra);

    // IO write to channel 1
    wr0 = wr_cnt; stb0 = stb_cnt;
    txn("io_wr", M_WRITE, 9'h101, 16'h00A5, 16'hBEEF, 1'b0, 3, ra);
    chk("io_wr.io_out1", 32'(io_out[31:16]), 32'h00A5);
    chk("io_wr.io_out0", 32'(io_out[15:0]), 32'h0000);
    chk("io_wr.strobe_cnt", 32'(stb_cnt - stb0), 32'd1);
    chk("io_wr.strobe_mask", 32'(stb_last), 32'h2);
    chk("io_wr.no_ram_write", 32'(wr_cnt - wr0), 32'd0);

    // IO reads, both channels
    io_in = {16'hCAFE, 16'h1234};
    txn("io_rd0", M_READ, 9'h100, 16'h0000, 16'h1234, 1'b0, 3, ra);
    txn("io_rd1", M_READ, 9'h101, 16'h0000, 16'hCAFE, 1'b0, 3, ra);

    // unmapped read: index beyond N_IO
    txn("err_rd", M_READ, 9'h102, 16'h0000, 16'h0000, 1'b1, 3, ra);

    // unmapped write: stray upper IO bit
    wr0 = wr_cnt; stb0 = stb_cnt;
    txn("err_wr", M_WRITE, 9'h180, 16'hFFFF, 16'h0000, 1'b1, 3, ra);
    chk("err_wr.io_out", io_out, {16'h00A5, 16'h0000});
    chk("err_wr.no_strobe", 32'(stb_cnt - stb0), 32'd0);
    chk("err_wr.no_ram_write", 32'(wr_cnt - wr0), 32'd0);

    // illegal command 11
    txn("illegal", 2'b11, 9'h023, 16'hFFFF, 16'h0000, 1'b1, 1, ra);
    chk("illegal.no_strobe", 32'(stb_cnt - stb0), 32'd0);
    chk("illegal.no_ram_write", 32'(wr_cnt - wr0), 32'd0);
    chk("illegal.io_out", io_out, {16'h00A5, 16'h0000});

    // error flag clears on the next good access
    txn("ram_rd2", M_READ, 9'h023, 16'h0000, 16'hBEEF, 1'b0, 3, ra);

    // reset in the first ACCESS cycle of a RAM write
    txn("ram_wr10", M_WRITE, 9'h010, 16'h5A5A, 16'hBEEF, 1'b0, 3, ra);
    wr0 = wr_cnt;
    @(negedge clk);
    mem_cmd = M_WRITE; mem_addr = 9'h010; cpu_wdata = 16'hDEAD;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_cmd = M_NOP;
    @(negedge clk);
    chk("rst_mid.ram_write_gated", 32'(ram_write), 32'd0);
    @(negedge clk);
    chk("rst_mid.cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_mid.bus_err", 32'(bus_err), 32'd0);
    chk("rst_mid.io_out", io_out, 32'd0);
    chk("rst_mid.io_wstrobe", 32'(io_wstrobe), 32'd0);
    chk("rst_mid.ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_mid.ram_din", 32'(ram_din), 32'd0);
    reset = 1'b1;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_ready === 1'b1) rdy_seen = 1;
    end
    chk("rst_mid.no_ready", 32'(rdy_seen), 32'd0);
    chk("rst_mid.no_ram_write", 32'(wr_cnt - wr0), 32'd0);
    txn("rst_mid.readback", M_READ, 9'h010, 16'h0000, 16'h5A5A, 1'b0, 3, ra);

    // held-read cadence: WAIT=0 ready at 2,5,8..; WAIT=3 ready at 5,11,..
    @(negedge clk);
    a_cmd = M_READ; b_cmd = M_READ;
    na = 0; nb = 0; pa = 0; pb = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (a_ready === 1'b1) begin
        chk("w0.gap", 32'(i - pa), (na == 0) ? 32'd2 : 32'd3);
        chk("w0.rdata", 32'(a_rdata), 32'hA045);
        chk("w0.bus_err", 32'(a_err), 32'd0);
        pa = i; na++;
      end
      if (b_ready === 1'b1) begin
        chk("w3.gap", 32'(i - pb), (nb == 0) ? 32'd5 : 32'd6);
        chk("w3.rdata", 32'(b_rdata), 32'h7E57);
        chk("w3.bus_err", 32'(b_err), 32'd0);
        pb = i; nb++;
      end
    end
    chk("w0.count", 32'(na), 32'd10);
    chk("w3.count", 32'(nb), 32'd5);
    a_cmd = M_NOP; b_cmd = M_NOP;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
